// File: rtl/mii_rx_frame_checker_if.sv
// MII receive nibble stream into the frame checker plus its per-frame status and counters.
// The checker takes the slave side; the nibble source or bench takes the master side.
interface mii_rx_frame_checker_if #(
    parameter int CNT_W = 16
);
    logic             i_rx_dv;
    logic             i_rx_er;
    logic [3:0]       i_rxd;
    logic [15:0]      o_word;
    logic             o_word_vld;
    logic             o_frame_done;
    logic             o_crc_ok;
    logic [10:0]      o_len_bytes;
    logic [CNT_W-1:0] o_frm_cnt;
    logic [CNT_W-1:0] o_err_cnt;

    modport master (
        output i_rx_dv, i_rx_er, i_rxd,
        input  o_word, o_word_vld, o_frame_done, o_crc_ok, o_len_bytes, o_frm_cnt, o_err_cnt
    );

    modport slave (
        input  i_rx_dv, i_rx_er, i_rxd,
        output o_word, o_word_vld, o_frame_done, o_crc_ok, o_len_bytes, o_frm_cnt, o_err_cnt
    );
endinterface

// File: rtl/mii_rx_frame_checker.sv
// MII receive frame checker: finds preamble/SFD, rebuilds bytes and 16-bit words, checks the FCS
// and keeps wrapping frame/error counters.
//
// state    | meaning
// IDLE     | between frames, waiting for the first 0x5 preamble nibble
// PREAMBLE | counting 0x5 nibbles, waiting for the 0xD SFD
// DATA     | assembling bytes/words and running the CRC
// CHECK    | one cycle: flush the half word, publish status, bump counters
// DROP     | bad preamble or oversize frame, wait for dv to fall
module mii_rx_frame_checker #(
    parameter int MIN_PRE   = 7,
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518,
    parameter int CNT_W     = 16
) (
    input  logic                    i_clk_125m,
    input  logic                    i_rst_n,
    mii_rx_frame_checker_if.slave   rx
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, CHECK, DROP} state_t;

    state_t           state_q;
    logic             dv_q, er_q;
    logic [3:0]       rxd_q;
    logic [3:0]       pre_cnt_q;
    logic [10:0]      byte_cnt_q;
    logic             phase_q;
    logic             err_q;
    logic [3:0]       lo_q;
    logic [7:0]       hi_q;
    logic [31:0]      crc_q;
    logic [15:0]      word_q;
    logic             word_vld_q;
    logic             done_q;
    logic             crc_ok_q;
    logic [10:0]      len_q;
    logic [CNT_W-1:0] frm_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [7:0]       byte_d;
    logic [31:0]      crc_d;
    logic             crc_ok_d;

    // Reflected CRC-32, one byte LSB first; no final inversion, so a clean frame leaves the residue.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        byte_d   = {rxd_q, lo_q};
        crc_d    = crc_byte(crc_q, byte_d);
        crc_ok_d = (crc_q == 32'hDEBB20E3) && !err_q && !phase_q &&
                   (byte_cnt_q >= 11'(MIN_BYTES));
    end

    always_ff @(posedge i_clk_125m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            dv_q       <= 1'b0;
            er_q       <= 1'b0;
            rxd_q      <= 4'h0;
            pre_cnt_q  <= 4'd0;
            byte_cnt_q <= 11'd0;
            phase_q    <= 1'b0;
            err_q      <= 1'b0;
            lo_q       <= 4'h0;
            hi_q       <= 8'h00;
            crc_q      <= 32'hFFFFFFFF;
            word_q     <= 16'h0000;
            word_vld_q <= 1'b0;
            done_q     <= 1'b0;
            crc_ok_q   <= 1'b0;
            len_q      <= 11'd0;
            frm_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            dv_q       <= rx.i_rx_dv;
            er_q       <= rx.i_rx_er;
            rxd_q      <= rx.i_rxd;
            word_vld_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    pre_cnt_q  <= 4'd0;
                    byte_cnt_q <= 11'd0;
                    phase_q    <= 1'b0;
                    err_q      <= 1'b0;
                    crc_q      <= 32'hFFFFFFFF;
                    if (dv_q && rxd_q == 4'h5) begin
                        pre_cnt_q <= 4'd1;
                        state_q   <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (!dv_q) begin
                        state_q <= IDLE;
                    end else if (rxd_q == 4'h5) begin
                        if (pre_cnt_q != 4'd15) pre_cnt_q <= pre_cnt_q + 4'd1;
                    end else if (rxd_q == 4'hD && pre_cnt_q >= 4'(MIN_PRE)) begin
                        state_q <= DATA;
                    end else begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    if (!dv_q) begin
                        state_q <= CHECK;
                    end else begin
                        if (er_q) err_q <= 1'b1;
                        phase_q <= ~phase_q;
                        if (!phase_q) begin
                            lo_q <= rxd_q;
                        end else begin
                            crc_q      <= crc_d;
                            byte_cnt_q <= byte_cnt_q + 11'd1;
                            if (!byte_cnt_q[0]) begin
                                hi_q <= byte_d;
                            end else begin
                                word_q     <= {hi_q, byte_d};
                                word_vld_q <= 1'b1;
                            end
                            if (byte_cnt_q == 11'(MAX_BYTES)) state_q <= DROP;
                        end
                    end
                end
                CHECK: begin
                    if (byte_cnt_q[0]) begin
                        word_q     <= {hi_q, 8'h00};
                        word_vld_q <= 1'b1;
                    end
                    done_q    <= 1'b1;
                    crc_ok_q  <= crc_ok_d;
                    len_q     <= byte_cnt_q;
                    frm_cnt_q <= frm_cnt_q + 1'b1;
                    if (!crc_ok_d) err_cnt_q <= err_cnt_q + 1'b1;
                    state_q   <= IDLE;
                end
                DROP: begin
                    // Byte count is frozen on entry, so it never exceeds MAX_BYTES+1.
                    if (!dv_q) begin
                        done_q    <= 1'b1;
                        crc_ok_q  <= 1'b0;
                        len_q     <= byte_cnt_q;
                        frm_cnt_q <= frm_cnt_q + 1'b1;
                        err_cnt_q <= err_cnt_q + 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx.o_word       = word_q;
    assign rx.o_word_vld   = word_vld_q;
    assign rx.o_frame_done = done_q;
    assign rx.o_crc_ok     = crc_ok_q;
    assign rx.o_len_bytes  = len_q;
    assign rx.o_frm_cnt    = frm_cnt_q;
    assign rx.o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_mii_rx_frame_checker.sv
// Directed bench for mii_rx_frame_checker: expected words and frame status are queued as the
// nibbles are driven and compared when the checker strobes them out.
module tb_mii_rx_frame_checker;
    localparam int MIN_PRE = 7;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic        ok;
        logic [10:0] len;
        logic [15:0] frm;
        logic [15:0] err;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    mii_rx_frame_checker_if #(.CNT_W(16)) bus();

    mii_rx_frame_checker #(
        .MIN_PRE(MIN_PRE), .MIN_BYTES(64), .MAX_BYTES(1518), .CNT_W(16)
    ) dut (
        .i_clk_125m(clk),
        .i_rst_n   (rst_n),
        .rx        (bus)
    );

    logic [15:0] word_sb[$];
    done_t       done_sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_frm = 16'd0;
    logic [15:0] exp_err = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input bq_t b);
        logic [31:0] c;
        logic [7:0]  v;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            v = b[i];
            for (int k = 0; k < 8; k++) c = (c[0] ^ v[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bq_t nominal_payload();
        bq_t p;
        logic [7:0] hdr[20] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03,
                                8'h04, 8'h01, 8'h14, 8'h37, 8'h10, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h01};
        foreach (hdr[i]) p.push_back(hdr[i]);
        for (int i = 0; i < 40; i++) p.push_back(8'h00);
        return p;
    endfunction

    function automatic bq_t add_fcs(input bq_t p);
        logic [31:0] f;
        f = ~crc32(p);
        p.push_back(f[7:0]);
        p.push_back(f[15:8]);
        p.push_back(f[23:16]);
        p.push_back(f[31:24]);
        return p;
    endfunction

    task automatic drive(input logic dv, input logic er, input logic [3:0] n);
        bus.i_rx_dv = dv;
        bus.i_rx_er = er;
        bus.i_rxd   = n;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        for (int k = 0; k < 40 && (word_sb.size() != 0 || done_sb.size() != 0); k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("word_sb_drained", 32'(word_sb.size()), 32'd0);
        chk("done_sb_drained", 32'(done_sb.size()), 32'd0);
    endtask

    task automatic send_frame(input bq_t b, input int pre_n, input bit extra_nib,
                              input int er_byte, input bit exp_ok);
        logic [7:0] v, pv;
        bit         push;
        done_t      d;
        push = (pre_n >= MIN_PRE);
        pv = 8'h00;
        for (int i = 0; i < pre_n; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        foreach (b[i]) begin
            v = b[i];
            drive(1'b1, (i == er_byte), v[3:0]);
            drive(1'b1, 1'b0, v[7:4]);
            if (push && (i % 2) == 1) word_sb.push_back({pv, v});
            pv = v;
        end
        if (push && (b.size() % 2) == 1) word_sb.push_back({pv, 8'h00});
        if (extra_nib) drive(1'b1, 1'b0, 4'h3);
        exp_frm = exp_frm + 16'd1;
        if (!exp_ok) exp_err = exp_err + 16'd1;
        d.ok  = exp_ok;
        d.len = push ? 11'(b.size()) : 11'd0;
        d.frm = exp_frm;
        d.err = exp_err;
        done_sb.push_back(d);
        drive(1'b0, 1'b0, 4'h0);
        settle();
    endtask

    always @(negedge clk) begin : monitor
        done_t d;
        if (rst_n && bus.o_word_vld) begin
            if (word_sb.size() == 0) chk("word_unexpected", 32'(word_sb.size()), 32'd1);
            else chk("word", 32'(bus.o_word), 32'(word_sb.pop_front()));
        end
        if (rst_n && bus.o_frame_done) begin
            if (done_sb.size() == 0) begin
                chk("done_unexpected", 32'(done_sb.size()), 32'd1);
            end else begin
                d = done_sb.pop_front();
                chk("crc_ok", 32'(bus.o_crc_ok), 32'(d.ok));
                chk("len_bytes", 32'(bus.o_len_bytes), 32'(d.len));
                chk("frm_cnt", 32'(bus.o_frm_cnt), 32'(d.frm));
                chk("err_cnt", 32'(bus.o_err_cnt), 32'(d.err));
            end
        end
    end

    initial begin
        bq_t nom, bad, runt, b65, p;
        logic [7:0] v, pv;
        bus.i_rx_dv = 1'b0;
        bus.i_rx_er = 1'b0;
        bus.i_rxd   = 4'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_word", 32'(bus.o_word), 32'd0);
        chk("rst_word_vld", 32'(bus.o_word_vld), 32'd0);
        chk("rst_done", 32'(bus.o_frame_done), 32'd0);
        chk("rst_crc_ok", 32'(bus.o_crc_ok), 32'd0);
        chk("rst_len", 32'(bus.o_len_bytes), 32'd0);
        chk("rst_frm_cnt", 32'(bus.o_frm_cnt), 32'd0);
        chk("rst_err_cnt", 32'(bus.o_err_cnt), 32'd0);

        nom = add_fcs(nominal_payload());
        send_frame(nom, 15, 1'b0, -1, 1'b1);

        bad = nom;
        bad[20] = bad[20] ^ 8'h01;
        send_frame(bad, 15, 1'b0, -1, 1'b0);

        send_frame(nom, 4, 1'b0, -1, 1'b0);

        repeat (3) drive(1'b1, 1'b0, 4'h5);
        repeat (10) drive(1'b0, 1'b0, 4'h0);
        chk("pre_abort_frm", 32'(bus.o_frm_cnt), 32'(exp_frm));
        chk("pre_abort_err", 32'(bus.o_err_cnt), 32'(exp_err));

        p = nominal_payload();
        repeat (4) void'(p.pop_back());
        runt = add_fcs(p);
        send_frame(runt, 15, 1'b0, -1, 1'b0);

        send_frame(nom, 15, 1'b0, 10, 1'b0);
        send_frame(nom, 15, 1'b1, -1, 1'b0);

        b65 = nom;
        b65.push_back(8'hAB);
        send_frame(b65, 15, 1'b0, -1, 1'b0);

        // Abort a frame with reset after 20 bytes; only the words already completed come out.
        pv = 8'h00;
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 20; i++) begin
            v = nom[i];
            drive(1'b1, 1'b0, v[3:0]);
            drive(1'b1, 1'b0, v[7:4]);
            if ((i % 2) == 1) word_sb.push_back({pv, v});
            pv = v;
        end
        drive(1'b1, 1'b0, 4'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.i_rx_dv = 1'b0;
        exp_frm = 16'd0;
        exp_err = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) drive(1'b0, 1'b0, 4'h0);
        chk("rst_mid_frm", 32'(bus.o_frm_cnt), 32'd0);
        chk("rst_mid_err", 32'(bus.o_err_cnt), 32'd0);
        chk("rst_mid_word_sb", 32'(word_sb.size()), 32'd0);

        send_frame(nom, 15, 1'b0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
